seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter LZ_BLANK, default 1, meaning 1 blanks a zero hours-tens digit.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port min_units  input  4  BCD 0-9, from the modulo-10 counter.
REQ-006 SHALL have port min_tens  input  3  value 0-5, from the modulo-6 counter.
REQ-007 SHALL have port hr_units  input  4  BCD 0-9.
REQ-008 SHALL have port hr_tens  input  2  value 0-2.
REQ-009 SHALL have port colon  input  1  1 lights the decimal point of digit 2.
REQ-010 SHALL have port blink_mask  input  4  one bit per digit, 1 = digit under adjustment (used only when BLINK_EN is defined).
REQ-011 SHALL have port anode  output  4  active-low digit enables; bit0 = min_units, bit3 = hr_tens.
REQ-012 SHALL have port seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-013 SHALL have port dp  output  1  active-low decimal point.

Function
REQ-014 SHALL run a prescaler counting 0..SCAN_DIV-1, wrapping to 0 and asserting a one-cycle internal tick at SCAN_DIV-1.
REQ-015 SHALL hold a 2-bit digit index; it increments on tick and wraps from 3 to 0.
REQ-016 SHALL register anode, seg and dp so that they reflect the new index one clk after the index changes (latency 1).
REQ-017 SHALL drive exactly one anode bit low at all times after the first post-reset cycle.
REQ-018 SHALL sample the selected digit input on the same cycle it is decoded; no snapshot across digits.
REQ-019 SHALL zero-extend min_tens and hr_tens to 4 bits before decoding.
REQ-020 SHALL decode values 0-9 to standard segment patterns; any value 10-15 SHALL produce seg = 7'b1111111 (blank).
REQ-021 SHALL, when LZ_BLANK=1 and the index is 3 and hr_tens=0, drive seg all-off while anode[3] is still driven low.
REQ-022 SHALL drive dp low only when index=2 and colon=1; otherwise dp=1.
REQ-023 SHALL let input changes mid-slot appear on seg on the next clk (no hold until the slot boundary).

Reset
REQ-024 SHALL, on rst=1 at a clk edge, clear the prescaler and index to 0, set anode=4'b1111, seg=7'b1111111 and dp=1.
REQ-025 SHALL, on rst asserted mid-slot, abandon the slot; after rst deasserts the first tick occurs SCAN_DIV cycles later, and the index-0 display appears one cycle after rst deasserts.

Configuration
REQ-026 SHALL, when macro SEG_SCAN_BLINK_EN is defined, add a blink counter toggling a 2 Hz-equivalent phase every 64*SCAN_DIV clk cycles, reset to phase "on".
REQ-027 SHALL, with SEG_SCAN_BLINK_EN defined, blank seg and dp for the current digit when its blink_mask bit is 1 and the phase is "off"; anode is unaffected.
REQ-028 SHALL, without SEG_SCAN_BLINK_EN, omit the blink counter, ignore blink_mask, and never blank for blinking.

Structure
REQ-029 SHALL take segment pattern constants (digits 0-9, SEG_BLANK) and the digit-index encoding from a shared package seg_pkg.
REQ-030 SHALL place the decoding in a single combinational sub-module bcd_to_7seg (4-bit in, 7-bit active-low out).

Verification
REQ-031 Reset: SCAN_DIV=4, hold rst for 3 cycles -> anode=1111, seg=1111111, dp=1; one cycle after release -> anode=1110.
REQ-032 Scan order: SCAN_DIV=4, inputs 1,2,3,4 (hr_tens=1) -> anode steps 1110,1101,1011,0111 every 4 cycles and wraps; seg codes = digits 4,3,2,1.
REQ-033 Leading zero: hr_tens=0, LZ_BLANK=1 -> during anode=0111, seg=1111111; with LZ_BLANK=0 -> seg = zero pattern.
REQ-034 Out-of-range/colon: min_units=4'hC -> blank in slot 0; colon=1 -> dp=0 only while anode=1011.
REQ-035 Blink (SEG_SCAN_BLINK_EN, SCAN_DIV=4): blink_mask=0001 -> slot-0 seg alternates between pattern and blank every 256 cycles; other slots are never blanked.
REQ-036 Mid-slot reset: assert rst at prescaler=2 in slot 2 -> next cycle in reset state; scan restarts at slot 0 with a full 4-cycle slot.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared segment patterns (active-low {g,f,e,d,c,b,a}) and the
//               digit-slot index encoding for the 4-digit clock display.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        DIG_MIN_UNITS = 2'd0,
        DIG_MIN_TENS  = 2'd1,
        DIG_HR_UNITS  = 2'd2,
        DIG_HR_TENS   = 2'd3
    } digit_idx_t;

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to active-low 7-segment decoder; codes
//               10-15 decode to a blank digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed 4-digit HH:MM seven-segment scan driver.
//               Define SEG_SCAN_BLINK_EN to enable per-digit blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int LZ_BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min_units,
    input  logic [2:0] min_tens,
    input  logic [3:0] hr_units,
    input  logic [1:0] hr_tens,
    input  logic       colon,
    input  logic [3:0] blink_mask,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int c_PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam bit c_LZ_ON = (LZ_BLANK != 0);

    logic [c_PW-1:0] r_presc;
    digit_idx_t      r_idx;
    logic [3:0]      r_anode;
    logic [6:0]      r_seg;
    logic            r_dp;

    logic            w_tick;
    logic [3:0]      w_digit;
    logic [6:0]      w_seg_dec;
    logic [3:0]      w_anode;
    logic            w_lz_blank;
    logic            w_blink_off;

    assign w_tick = (r_presc == c_PW'(SCAN_DIV - 1));

    // Digit is picked and decoded live from the counter inputs every cycle.
    always_comb begin
        w_digit = 4'd0;
        case (r_idx)
            DIG_MIN_UNITS: w_digit = min_units;
            DIG_MIN_TENS:  w_digit = {1'b0, min_tens};
            DIG_HR_UNITS:  w_digit = hr_units;
            DIG_HR_TENS:   w_digit = {2'b00, hr_tens};
            default:       w_digit = 4'd0;
        endcase
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg_dec)
    );

    assign w_anode    = ~(4'b0001 << r_idx);
    assign w_lz_blank = c_LZ_ON && (r_idx == DIG_HR_TENS) && (hr_tens == 2'd0);

`ifdef SEG_SCAN_BLINK_EN
    logic [5:0] r_blink_cnt;
    logic       r_phase_on;

    // Phase flips once every 64 scan ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= 6'd0;
            r_phase_on  <= 1'b1;
        end else if (w_tick) begin
            r_blink_cnt <= r_blink_cnt + 6'd1;
            if (r_blink_cnt == 6'd63) begin
                r_phase_on <= ~r_phase_on;
            end
        end
    end

    assign w_blink_off = blink_mask[r_idx] && !r_phase_on;
`else
    logic w_unused_blink;
    assign w_unused_blink = &{1'b0, blink_mask};
    assign w_blink_off    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= DIG_MIN_UNITS;
            r_anode <= 4'b1111;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) begin
                r_idx <= digit_idx_t'(r_idx + 2'd1);
            end
            r_anode <= w_anode;
            r_seg   <= (w_lz_blank || w_blink_off) ? SEG_BLANK : w_seg_dec;
            r_dp    <= !((r_idx == DIG_HR_UNITS) && colon && !w_blink_off);
        end
    end

    assign anode = r_anode;
    assign seg   = r_seg;
    assign dp    = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver (LZ_BLANK=1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] min_units = 4'd0;
    logic [2:0] min_tens = 3'd0;
    logic [3:0] hr_units = 4'd0;
    logic [1:0] hr_tens = 2'd0;
    logic       colon = 1'b0;
    logic [3:0] blink_mask = 4'd0;

    logic [3:0] anode_a, anode_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;

    int errors = 0;
    int checks = 0;
    int k = 0;

    logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
    } exp_t;

    exp_t sb[$];

    seg_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(1)) u_dut_lz (
        .clk(clk), .rst(rst), .min_units(min_units), .min_tens(min_tens),
        .hr_units(hr_units), .hr_tens(hr_tens), .colon(colon),
        .blink_mask(blink_mask), .anode(anode_a), .seg(seg_a), .dp(dp_a)
    );

    seg_scan_driver #(.SCAN_DIV(SD), .LZ_BLANK(0)) u_dut_nolz (
        .clk(clk), .rst(rst), .min_units(min_units), .min_tens(min_tens),
        .hr_units(hr_units), .hr_tens(hr_tens), .colon(colon),
        .blink_mask(blink_mask), .anode(anode_b), .seg(seg_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    // Expected outputs follow from the number of clocks since reset release.
    task automatic push_and_clock();
        exp_t       e;
        int         slot;
        logic [3:0] v;
        logic [6:0] s;
        logic [3:0] an;
        logic       d;
        logic       blink_off;
        if (rst) begin
            k   = 0;
            e.a = {4'hF, 7'h7F, 1'b1};
            e.b = e.a;
        end else begin
            k++;
            slot = ((k - 1) / SD) % 4;
            case (slot)
                0:       v = min_units;
                1:       v = {1'b0, min_tens};
                2:       v = hr_units;
                default: v = {2'b00, hr_tens};
            endcase
            s = (v > 4'd9) ? 7'h7F : pat[v];
            blink_off = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
            blink_off = blink_mask[slot] && ((((k - 1) / SD / 64) % 2) == 1);
`endif
            an  = ~(4'b0001 << slot);
            d   = !(slot == 2 && colon) || blink_off;
            e.b = {an, blink_off ? 7'h7F : s, d};
            e.a = {an, (blink_off || (slot == 3 && hr_tens == 2'd0)) ? 7'h7F : s, d};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_and_clock();
            e = sb.pop_front();
            checks++;
            if ({anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
                errors++;
                $display("FAIL reset: got %h expected %h",
                         {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
            end
        end
        rst = 1'b0;
        push_and_clock();
        e = sb.pop_front();
        checks++;
        if (anode_a !== 4'b1110 || {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h (anode 1110)",
                     {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
        end
    endtask

    task automatic test_scan_order();
        exp_t e;
        hr_tens = 2'd1; hr_units = 4'd2; min_tens = 3'd3; min_units = 4'd4;
        rst = 1'b1;
        push_and_clock();
        void'(sb.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            push_and_clock();
            e = sb.pop_front();
            checks++;
            if ({anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
                errors++;
                $display("FAIL scan_order cyc %0d: got %h expected %h", i,
                         {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
            end
        end
    endtask

    task automatic test_leading_zero();
        exp_t e;
        int   seen = 0;
        hr_tens = 2'd0; hr_units = 4'd9;
        for (int i = 0; i < 20; i++) begin
            push_and_clock();
            e = sb.pop_front();
            checks++;
            if ({anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
                errors++;
                $display("FAIL leading_zero cyc %0d: got %h expected %h", i,
                         {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
            end
            if (anode_a == 4'b0111) seen++;
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL leading_zero_slot: got %0d slot-3 cycles required >0", seen);
        end
    endtask

    task automatic test_out_of_range_colon();
        exp_t e;
        min_units = 4'hC; colon = 1'b1; hr_tens = 2'd2;
        for (int i = 0; i < 24; i++) begin
            push_and_clock();
            e = sb.pop_front();
            checks++;
            if ({anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
                errors++;
                $display("FAIL oor_colon cyc %0d: got %h expected %h", i,
                         {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
            end
        end
        colon = 1'b0;
    endtask

    task automatic test_mid_slot_change();
        exp_t e;
        min_units = 4'd1;
        rst = 1'b1;
        push_and_clock();
        void'(sb.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) min_units = 4'd7;
            if (i == 3) min_units = 4'd5;
            push_and_clock();
            e = sb.pop_front();
            checks++;
            if ({anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
                errors++;
                $display("FAIL mid_slot_change cyc %0d: got %h expected %h", i,
                         {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
            end
        end
    endtask

    task automatic test_mid_slot_reset();
        exp_t e;
        int   slot0_len = 0;
        rst = 1'b1;
        push_and_clock();
        void'(sb.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_and_clock();
            void'(sb.pop_front());
        end
        rst = 1'b1;
        push_and_clock();
        e = sb.pop_front();
        checks++;
        if ({anode_a, seg_a, dp_a} !== {4'hF, 7'h7F, 1'b1} || {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
            errors++;
            $display("FAIL mid_slot_reset_state: got %h expected %h",
                     {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_and_clock();
            e = sb.pop_front();
            checks++;
            if ({anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
                errors++;
                $display("FAIL mid_slot_reset cyc %0d: got %h expected %h", i,
                         {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
            end
            if (anode_a == 4'b1110) slot0_len++;
        end
        checks++;
        if (slot0_len != SD) begin
            errors++;
            $display("FAIL mid_slot_reset_len: got %0d slot-0 cycles required %0d", slot0_len, SD);
        end
    endtask

    task automatic test_blink();
        exp_t e;
        int   n;
        min_units = 4'd8; min_tens = 3'd5; hr_units = 4'd3; hr_tens = 2'd1;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = 4'b0001;
        n = 1100;
`else
        blink_mask = 4'b1111;
        n = 24;
`endif
        rst = 1'b1;
        push_and_clock();
        void'(sb.pop_front());
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_and_clock();
            e = sb.pop_front();
            checks++;
            if ({anode_a, seg_a, dp_a, anode_b, seg_b, dp_b} !== {e.a, e.b}) begin
                errors++;
                $display("FAIL blink cyc %0d: got %h expected %h", i,
                         {anode_a, seg_a, dp_a, anode_b, seg_b, dp_b}, {e.a, e.b});
            end
        end
        blink_mask = 4'd0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_leading_zero();
        test_out_of_range_colon();
        test_mid_slot_change();
        test_mid_slot_reset();
        test_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
